shift_add_multiplier: RTL and testbench

Iterative unsigned multiplier that sits directly downstream of the team's 4-bit ripple-carry adder (FourBitAdder). It instantiates that adder as its only arithmetic element and consumes its sum and carry once per clock to form a 2·WIDTH-bit product by shift-and-add. It gives the datapath a multiply operation without a combinational array multiplier, and uses a start/busy/done handshake toward its controller.

---
 rtl/shift_add_multiplier.sv | 129 ++++++++++++
 tb/tb_shift_add_multiplier.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Unsigned shift-and-add multiplier built on chained FourBitAdder slices; one add+shift per clock.
// Latency WIDTH edges from accepting start to registered done; start is ignored while busy.

module FourBitAdder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] w_c;

    assign w_c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fa
            assign sum[gi]    = a[gi] ^ b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = w_c[4];
endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);
    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic               r_done;

    logic               w_load;
    logic               w_last;
    logic [WIDTH-1:0]   w_sum;
    logic [NSLICE:0]    w_carry;
    logic [WIDTH:0]     w_x;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_q_nxt;

    assign w_carry[0] = 1'b0;

    genvar gs;
    generate
        for (gs = 0; gs < NSLICE; gs++) begin : g_slice
            FourBitAdder u_add (
                .a    (r_acc[4*gs +: 4]),
                .b    (r_m[4*gs +: 4]),
                .cin  (w_carry[gs]),
                .sum  (w_sum[4*gs +: 4]),
                .cout (w_carry[gs+1])
            );
        end
    endgenerate

    // Carry is kept as the top bit of X so the shifted result never overflows.
    assign w_x       = r_q[0] ? {w_carry[NSLICE], w_sum} : {1'b0, r_acc};
    assign w_acc_nxt = w_x[WIDTH:1];
    assign w_q_nxt   = {w_x[0], r_q[WIDTH-1:1]};

    assign w_load = (r_state == IDLE) && start;
    assign w_last = (r_state == RUN) && (r_cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m    <= '0;
            r_acc  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_p    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_m   <= A;
                r_q   <= B;
                r_acc <= '0;
                r_cnt <= CW'(WIDTH);
            end else if (r_state == RUN) begin
                r_acc <= w_acc_nxt;
                r_q   <= w_q_nxt;
                r_cnt <= r_cnt - CW'(1);
                if (w_last) begin
                    r_p <= {w_acc_nxt, w_q_nxt};
                end
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign P    = r_p;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier at WIDTH=4; outputs sampled on the falling edge.
module tb_shift_add_multiplier;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [7:0] P;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    shift_add_multiplier #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits up to max_k falling edges for done; returns edges waited and busy-high samples seen.
    task automatic wait_done(input int max_k, output int k, output int nbusy);
        k = 0;
        nbusy = 0;
        while (k < max_k) begin
            @(negedge clk);
            k++;
            if (done) break;
            if (busy) nbusy++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp);
        int k, nb, extra;
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy0"}, 32'(busy), 32'd1);
        wait_done(12, k, nb);
        chk({tag, "_lat"}, k, 4);
        chk({tag, "_busy_cycles"}, nb + 1, 4);
        chk({tag, "_P"}, 32'(P), 32'(exp));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) extra++;
            chk({tag, "_P_hold"}, 32'(P), 32'(exp));
        end
        chk({tag, "_single_done"}, extra, 0);
    endtask

    initial begin
        int k, nb, ndone, t_prev;
        logic [7:0] exp;
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_P", 32'(P), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_out", {22'd0, busy, done, P}, 32'd0);
        end

        run_op("m15x15", 4'd15, 4'd15, 8'hE1);
        run_op("m0x9",   4'd0,  4'd9,  8'h00);
        run_op("m9x0",   4'd9,  4'd0,  8'h00);
        run_op("m1x13",  4'd1,  4'd13, 8'h0D);
        run_op("m13x1",  4'd13, 4'd1,  8'h0D);

        // Second request two cycles into the operation must be ignored.
        A = 4'd3; B = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 4'd7; B = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(12, k, nb);
        chk("busy_ign_lat", k, 2);
        chk("busy_ign_P", 32'(P), 32'h0F);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
            chk("busy_ign_idle", 32'(busy), 32'd0);
        end
        chk("busy_ign_single_done", ndone, 0);
        chk("busy_ign_P_hold", 32'(P), 32'h0F);

        // Asynchronous reset between iteration edges 2 and 3.
        A = 4'd12; B = 4'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_P", 32'(P), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        chk("midrst_P_hold", 32'(P), 32'd0);
        run_op("m2x3", 4'd2, 4'd3, 8'h06);

        // Exhaustive sweep with start held high throughout.
        A = 4'd0; B = 4'd0; start = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            exp = 8'(i[7:4]) * 8'(i[3:0]);
            if (i == 255) begin
                start = 1'b0;
            end else begin
                A = 4'((i + 1) >> 4);
                B = 4'((i + 1) & 15);
            end
            wait_done(12, k, nb);
            chk($sformatf("sweep_lat_%0d", i), k, 4);
            chk($sformatf("sweep_P_%0dx%0d", i >> 4, i & 15), 32'(P), 32'(exp));
            if (i > 0) chk($sformatf("sweep_gap_%0d", i), cyc - t_prev, 5);
            t_prev = cyc;
        end
        @(negedge clk);
        chk("sweep_end_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
